// File: rtl/csi_rx_lane_align.sv
// csi_rx_lane_align
// Finds the HS sync byte independently on each D-PHY data lane, locks the
// bit offset per lane, and delays early lanes so the first packet byte
// leaves every lane of data_out in the same cycle.
//
// Ports
//   clock, reset      byte clock; synchronous active-high reset
//   enable            low freezes all state
//   deser_in          raw ISERDES bytes, lane n at [8n+7:8n]
//   wait_for_sync     permits a new sync search while hunting
//   packet_done       ends the packet and drops lock
//   valid_data        high while locked
//   data_out          aligned, deskewed bytes, lane n at [8n+7:8n]
//   lane_offs         locked bit offset per lane (3 bits each), zero unless locked
//   sync_err          one-cycle pulse when the lanes fail to sync within SKEW_MAX
module csi_rx_lane_align #(
    parameter int         NUM_LANES = 2,
    parameter logic [7:0] SYNC_BYTE = 8'hB8,
    parameter int         SKEW_MAX  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [8*NUM_LANES-1:0] deser_in,
    input  logic                   wait_for_sync,
    input  logic                   packet_done,
    output logic                   valid_data,
    output logic [8*NUM_LANES-1:0] data_out,
    output logic [3*NUM_LANES-1:0] lane_offs,
    output logic                   sync_err
);
    typedef enum logic [1:0] {HUNT, PARTIAL, LOCKED} state_e;

    state_e                               state_q, state_d;
    logic [NUM_LANES-1:0][7:0]            curr_q, curr_d, last_q, last_d;
    logic [NUM_LANES-1:0][SKEW_MAX:0][7:0] dl_q, dl_d;
    logic [NUM_LANES-1:0][2:0]            offs_q, offs_d;
    logic [NUM_LANES-1:0][2:0]            arr_q, arr_d;    // arrival, in cycles after first match
    logic [NUM_LANES-1:0][2:0]            dly_q, dly_d;
    logic [NUM_LANES-1:0]                 latched_q, latched_d;
    logic [2:0]                           cnt_q, cnt_d;    // cycles since first match
    logic                                 err_q, err_d;

    logic [NUM_LANES-1:0][15:0]           win;
    logic [NUM_LANES-1:0]                 hit;
    logic [NUM_LANES-1:0][2:0]            hit_off;

    // Mask of window bits [k:0], which must be zero below the sync byte.
    function automatic logic [15:0] low_mask(input int k);
        low_mask = 16'((32'd2 << k) - 32'd1);
    endfunction

    // Per-lane window, sync search and delay-line shift.
    always_comb begin
        curr_d = curr_q;
        last_d = last_q;
        dl_d   = dl_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            curr_d[l]  = deser_in[8*l +: 8];
            last_d[l]  = curr_q[l];
            win[l]     = {curr_q[l], last_q[l]};
            hit[l]     = 1'b0;
            hit_off[l] = 3'd0;
            // Ascending scan so the highest matching offset is the one kept.
            for (int k = 0; k < 8; k++) begin
                if (win[l][k+1 +: 8] == SYNC_BYTE && (win[l] & low_mask(k)) == 16'd0) begin
                    hit[l]     = 1'b1;
                    hit_off[l] = 3'(k);
                end
            end
            // The latched offset (not this cycle's hit) selects the byte, so the
            // header extracted the cycle after a match already uses the new offset.
            dl_d[l][0] = 8'(win[l] >> ({1'b0, offs_q[l]} + 4'd1));
            for (int i = 1; i <= SKEW_MAX; i++) dl_d[l][i] = dl_q[l][i-1];
        end
    end

    // Sync FSM.
    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        offs_d    = offs_q;
        arr_d     = arr_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        case (state_q)
            HUNT: begin
                if (wait_for_sync && (|hit)) begin
                    latched_d = hit;
                    cnt_d     = 3'd1;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (hit[l]) begin
                            offs_d[l] = hit_off[l];
                            arr_d[l]  = 3'd0;
                        end
                    end
                    if (&hit) begin
                        state_d = LOCKED;
                        dly_d   = '0;
                    end else if (SKEW_MAX == 0) begin
                        // No skew tolerated: a partial match is already a timeout.
                        err_d     = 1'b1;
                        latched_d = '0;
                    end else begin
                        state_d = PARTIAL;
                    end
                end
            end
            PARTIAL: begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (hit[l] && !latched_q[l]) begin
                        latched_d[l] = 1'b1;
                        offs_d[l]    = hit_off[l];
                        arr_d[l]     = cnt_q;
                    end
                end
                if (&latched_d) begin
                    state_d = LOCKED;
                    for (int l = 0; l < NUM_LANES; l++) dly_d[l] = cnt_q - arr_d[l];
                end else if (cnt_q >= 3'(SKEW_MAX)) begin
                    state_d   = HUNT;
                    err_d     = 1'b1;
                    latched_d = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: ;   // LOCKED holds offsets and delays
        endcase
        // End of packet overrides anything found this cycle.
        if (packet_done) begin
            state_d   = HUNT;
            latched_d = '0;
            offs_d    = offs_q;
            arr_d     = arr_q;
            dly_d     = dly_q;
            cnt_d     = cnt_q;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= HUNT;
            curr_q    <= '0;
            last_q    <= '0;
            dl_q      <= '0;
            offs_q    <= '0;
            arr_q     <= '0;
            dly_q     <= '0;
            latched_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            curr_q    <= curr_d;
            last_q    <= last_d;
            dl_q      <= dl_d;
            offs_q    <= offs_d;
            arr_q     <= arr_d;
            dly_q     <= dly_d;
            latched_q <= latched_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end else begin
            // A stall must not stretch the error pulse.
            err_q <= 1'b0;
        end
    end

    // Output select from each lane's delay line.
    always_comb begin
        data_out  = '0;
        lane_offs = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int i = 0; i <= SKEW_MAX; i++) begin
                if (dly_q[l] == 3'(i)) data_out[8*l +: 8] = dl_q[l][i];
            end
            if (state_q == LOCKED) lane_offs[3*l +: 3] = offs_q[l];
        end
    end

    assign valid_data = (state_q == LOCKED);
    assign sync_err   = err_q;

endmodule
